// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants, colour types and sync polarity helpers
package vga_pkg;

    localparam int CLK_DIV_DEF  = 5;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int RGB_W = 12;
    localparam logic [RGB_W-1:0] UNDERRUN_RGB_DEF = 12'hF0F;

    // 1 = sync pulses are active-low, so the idle level of HS/VS equals this bit
    localparam logic SYNC_NEG_DEF = 1'b1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HAVE
    } req_state_e;

    // Pin level of a sync output given whether the pulse is active
    function automatic logic sync_level(input logic active, input logic neg);
        return active ^ neg;
    endfunction

endpackage

// File: rtl/vga_pix_ce_gen.sv
// vga_pix_ce_gen: board-clock divider producing a one-clk pixel enable, held at origin while en is low
module vga_pix_ce_gen #(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pix_ce
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;

    assign pix_ce = en && (div_q == DIV_LAST);

    // Count 0..CLK_DIV-1, restart from 0 whenever the scan is disabled
    always_comb begin
        div_d = (!en || div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    // Divider state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

endmodule

// File: rtl/vga_scan_controller.sv
// vga_scan_controller: VGA scan timing, pixel request handshake and registered 12-bit RGB/sync outputs
module vga_scan_controller
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter logic SYNC_NEG = SYNC_NEG_DEF,
    parameter logic [RGB_W-1:0] UNDERRUN_RGB = UNDERRUN_RGB_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             req_valid,
    output logic [9:0]       req_x,
    output logic [9:0]       req_y,
    input  logic             req_ready,
    input  logic [RGB_W-1:0] req_rgb,
    output logic [3:0]       r,
    output logic [3:0]       g,
    output logic [3:0]       b,
    output logic             HS,
    output logic             VS,
    output logic             frame_start,
    output logic             underrun,
    input  logic             underrun_clr
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       pix_ce;
    logic       act, hs_fire, miss;
    logic [9:0] h_q, h_d, v_q, v_d;
    req_state_e state_q, state_d;
    rgb444_t    lat_q, lat_d, rgb_q, rgb_d;
    logic       hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, und_q, und_d;

    vga_pix_ce_gen #(.CLK_DIV(CLK_DIV)) u_ce (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .pix_ce (pix_ce)
    );

    assign req_valid   = (state_q == ST_REQ);
    assign req_x       = h_q;
    assign req_y       = v_q;
    assign {r, g, b}   = rgb_q;
    assign HS          = hs_q;
    assign VS          = vs_q;
    assign frame_start = fs_q;
    assign underrun    = und_q;

    // Scan advance, request FSM and output stage; outputs always describe the pixel the counters held at the last pix_ce
    always_comb begin
        act     = (h_q < H_ACT) && (v_q < V_ACT);
        hs_fire = (state_q == ST_REQ) && req_ready;
        h_d     = h_q;
        v_d     = v_q;
        state_d = state_q;
        lat_d   = lat_q;
        rgb_d   = rgb_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        fs_d    = 1'b0;
        miss    = 1'b0;
        if (!en) begin
            h_d     = '0;
            v_d     = '0;
            state_d = ST_IDLE;
            rgb_d   = '0;
            hs_d    = SYNC_NEG;
            vs_d    = SYNC_NEG;
        end else if (pix_ce) begin
            h_d     = (h_q == H_LAST) ? '0 : h_q + 10'd1;
            v_d     = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 10'd1;
            state_d = ST_IDLE;
            miss    = act && (state_q != ST_HAVE) && !hs_fire;
            rgb_d   = !act ? '0 :
                      (state_q == ST_HAVE) ? lat_q :
                      hs_fire ? rgb444_t'(req_rgb) : rgb444_t'(UNDERRUN_RGB);
            hs_d    = sync_level((h_q >= HS_LO) && (h_q < HS_HI), SYNC_NEG);
            vs_d    = sync_level((v_q >= VS_LO) && (v_q < VS_HI), SYNC_NEG);
            fs_d    = (h_q == H_LAST) && (v_q == V_LAST);
        end else if (state_q == ST_IDLE && act) begin
            state_d = ST_REQ;
        end else if (hs_fire) begin
            state_d = ST_HAVE;
            lat_d   = rgb444_t'(req_rgb);
        end
        und_d = miss || (und_q && !underrun_clr);
    end

    // All scan, handshake and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            state_q <= ST_IDLE;
            lat_q   <= '0;
            rgb_q   <= '0;
            hs_q    <= SYNC_NEG;
            vs_q    <= SYNC_NEG;
            fs_q    <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            state_q <= state_d;
            lat_q   <= lat_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
            und_q   <= und_d;
        end
    end

endmodule

// File: tb/tb_vga_scan_controller.sv
// tb_vga_scan_controller: reduced-timing scan checked against a pixel-index reference model plus directed vectors
module tb_vga_scan_controller;

    localparam int D   = 3;
    localparam int HA  = 8, HF = 2, HSW = 3, HB = 2;
    localparam int VA  = 6, VF = 1, VSW = 2, VB = 1;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VT  = VA + VF + VSW + VB;
    localparam int F   = HT * VT;
    localparam logic [11:0] COL = 12'hA53;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, req_ready = 1'b0, underrun_clr = 1'b0;
    logic [11:0] req_rgb = '0;
    logic        req_valid, HS, VS, frame_start, underrun;
    logic [9:0]  req_x, req_y;
    logic [3:0]  r, g, b;

    vga_scan_controller #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_ready(req_ready), .req_rgb(req_rgb),
        .r(r), .g(g), .b(b), .HS(HS), .VS(VS),
        .frame_start(frame_start), .underrun(underrun), .underrun_clr(underrun_clr)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;

    // Reference model: m_c counts enabled clock edges since the scan left its origin.
    // Pixel index = m_c / D, phase within the pixel = m_c % D.
    int          m_c, m_rx, m_ry;
    bit          m_served;
    logic [11:0] m_lat, m_out;
    logic        m_hs, m_vs, m_fs, m_und, m_rv;

    function automatic bit px_active(input int p);
        return ((p % HT) < HA) && (((p / HT) % VT) < VA);
    endfunction

    task automatic model_reset();
        m_c = 0; m_served = 0; m_lat = '0; m_out = '0;
        m_hs = 1'b1; m_vs = 1'b1; m_fs = 1'b0; m_und = 1'b0; m_rv = 1'b0;
        m_rx = 0; m_ry = 0;
    endtask

    task automatic model_step(input logic e, input logic rd, input logic [11:0] c, input logic cl);
        int p, ph, x, y;
        bit hsk, miss, a;
        hsk  = m_rv && rd;
        miss = 0;
        if (!e) begin
            m_c = 0; m_served = 0; m_out = '0; m_hs = 1'b1; m_vs = 1'b1; m_fs = 1'b0;
        end else begin
            p = m_c / D; ph = m_c % D; x = p % HT; y = (p / HT) % VT;
            m_fs = 1'b0;
            if (ph == D - 1) begin
                a     = (x < HA) && (y < VA);
                m_out = !a ? 12'h000 : m_served ? m_lat : hsk ? c : 12'hF0F;
                miss  = a && !m_served && !hsk;
                m_hs  = !((x >= HA + HF) && (x < HA + HF + HSW));
                m_vs  = !((y >= VA + VF) && (y < VA + VF + VSW));
                m_fs  = ((p % F) == F - 1);
                m_served = 0;
            end else if (hsk) begin
                m_served = 1; m_lat = c;
            end
            m_c++;
        end
        m_und = miss || (m_und && !cl);
        p = m_c / D; ph = m_c % D;
        m_rv = e && (ph >= 1) && !m_served && px_active(p);
        m_rx = p % HT; m_ry = (p / HT) % VT;
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("rgb", 32'({r, g, b}), 32'(m_out));
        chk("HS", 32'(HS), 32'(m_hs));
        chk("VS", 32'(VS), 32'(m_vs));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("underrun", 32'(underrun), 32'(m_und));
        chk("req_valid", 32'(req_valid), 32'(m_rv));
        if (m_rv) begin
            chk("req_x", 32'(req_x), 32'(m_rx));
            chk("req_y", 32'(req_y), 32'(m_ry));
        end
    endtask

    // One clock: drive at the falling edge, predict the next rising edge, check at the following falling edge
    task automatic cyc(input logic e, input logic rd, input logic [11:0] c, input logic cl);
        en = e; req_ready = rd; req_rgb = c; underrun_clr = cl;
        model_step(e, rd, c, cl);
        @(negedge clk);
        check_all();
    endtask

    // Run until the counters have just moved onto pixel (x,y)
    task automatic goto_px(input int x, input int y, input logic rd, input logic cl);
        int n;
        bit hit;
        n = 0;
        cyc(1'b1, rd, 12'h123, cl);
        hit = ((m_c / D) % F == y * HT + x) && (m_c % D == 0);
        while (!hit && n < F * D + D) begin
            cyc(1'b1, rd, 12'h123, cl);
            n++;
            hit = ((m_c / D) % F == y * HT + x) && (m_c % D == 0);
        end
        chk("goto_px", 32'(hit), 32'd1);
    endtask

    // mode 0: ready early (latched), 1: never ready (miss), 2: ready only in the pix_ce cycle (bypass)
    typedef struct {
        int          x, y, mode;
        logic [11:0] rgb;
        logic        und, hs, vs;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n, n_col, n_hs, n_vs, n_fs;
        tbl[0]  = '{0,  0, 0, COL,     1'b0, 1'b1, 1'b1};
        tbl[1]  = '{7,  5, 0, COL,     1'b0, 1'b1, 1'b1};
        tbl[2]  = '{8,  5, 0, 12'h000, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{7,  6, 0, 12'h000, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{3,  2, 1, 12'hF0F, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{4,  2, 2, COL,     1'b0, 1'b1, 1'b1};
        tbl[6]  = '{10, 1, 0, 12'h000, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{12, 1, 0, 12'h000, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{13, 1, 0, 12'h000, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{9,  1, 0, 12'h000, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{0,  7, 0, 12'h000, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{0,  9, 0, 12'h000, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{14, 8, 0, 12'h000, 1'b0, 1'b1, 1'b0};

        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;
        cyc(1'b0, 1'b0, 12'h000, 1'b0);
        cyc(1'b0, 1'b0, 12'h000, 1'b0);

        // Directed single-pixel vectors
        for (int i = 0; i < 13; i++) begin
            goto_px(tbl[i].x, tbl[i].y, 1'b1, 1'b1);
            cyc(1'b1, 1'b0, COL, 1'b0);
            cyc(1'b1, tbl[i].mode == 0, COL, 1'b0);
            cyc(1'b1, tbl[i].mode == 2, COL, 1'b0);
            chk($sformatf("vec%0d_rgb", i), 32'({r, g, b}), 32'(tbl[i].rgb));
            chk($sformatf("vec%0d_und", i), 32'(underrun), 32'(tbl[i].und));
            chk($sformatf("vec%0d_hs", i), 32'(HS), 32'(tbl[i].hs));
            chk($sformatf("vec%0d_vs", i), 32'(VS), 32'(tbl[i].vs));
        end

        // Miss with clear held high: set wins, then sticky, then cleared
        goto_px(3, 2, 1'b1, 1'b1);
        repeat (D) cyc(1'b1, 1'b0, COL, 1'b1);
        chk("und_set_wins", 32'(underrun), 32'd1);
        repeat (10) cyc(1'b1, 1'b1, COL, 1'b0);
        chk("und_sticky", 32'(underrun), 32'd1);
        cyc(1'b1, 1'b1, COL, 1'b1);
        chk("und_cleared", 32'(underrun), 32'd0);

        // Two full frames from the origin with an always-ready source
        repeat (3) cyc(1'b0, 1'b0, 12'h000, 1'b1);
        n_col = 0; n_hs = 0; n_vs = 0; n_fs = 0;
        for (int i = 0; i < 2 * F * D; i++) begin
            cyc(1'b1, 1'b1, COL, 1'b0);
            if (i < F * D && {r, g, b} == COL) n_col++;
            if (!HS) n_hs++;
            if (!VS) n_vs++;
            if (frame_start) n_fs++;
        end
        chk("frame_active_clks", 32'(n_col), 32'(HA * VA * D));
        chk("frame_hs_low_clks", 32'(n_hs), 32'(2 * VT * HSW * D));
        chk("frame_vs_low_clks", 32'(n_vs), 32'(2 * VSW * HT * D));
        chk("frame_start_count", 32'(n_fs), 32'd2);
        chk("frame_no_underrun", 32'(underrun), 32'd0);

        // Drop en mid-frame for 7 clk, then restart from the origin
        goto_px(3, 4, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, COL, 1'b0);
        cyc(1'b0, 1'b0, COL, 1'b0);
        chk("endrop_req_valid", 32'(req_valid), 32'd0);
        chk("endrop_rgb", 32'({r, g, b}), 32'd0);
        repeat (6) cyc(1'b0, 1'b0, COL, 1'b0);
        n = 0;
        while (!req_valid && n < 2 * D) begin
            cyc(1'b1, 1'b0, COL, 1'b0);
            n++;
        end
        chk("reen_req_valid", 32'(req_valid), 32'd1);
        chk("reen_req_x", 32'(req_x), 32'd0);
        chk("reen_req_y", 32'(req_y), 32'd0);
        chk("reen_within_div", 32'(n <= D), 32'd1);

        // Asynchronous reset between clock edges
        goto_px(1, 1, 1'b0, 1'b0);
        chk("und_before_rst", 32'(underrun), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_rgb", 32'({r, g, b}), 32'd0);
        chk("arst_hs", 32'(HS), 32'd1);
        chk("arst_vs", 32'(VS), 32'd1);
        chk("arst_req_valid", 32'(req_valid), 32'd0);
        chk("arst_underrun", 32'(underrun), 32'd0);
        chk("arst_frame_start", 32'(frame_start), 32'd0);
        @(negedge clk);
        model_reset();
        rst = 1'b0;

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 64) != 0, ($urandom % 4) != 0, 12'($urandom), ($urandom % 32) == 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/vga_scan_controller.md
Name: vga_scan_controller

Overview:
- Sequences the 12-bit VGA PMOD output path: R/G/B nibbles plus HS and VS.
- Divides the board clock into a pixel-clock enable and runs horizontal/vertical scan counters.
- For every active pixel, requests a colour from a pixel source over a valid/ready handshake, then drives registered RGB, HS and VS to the top level.
- Blanks the colour outputs outside the active area and flags late pixels (underrun).

Parameters:
- CLK_DIV, 5, board clk cycles per pixel (125 MHz -> 25 MHz); legal range 2..16
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, HS pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, VS pulse width
- V_BP, 33, vertical back porch
- SYNC_NEG, 1, 1 = sync pulses active-low
- UNDERRUN_RGB, 12'hF0F, colour driven when the source misses its window

Ports:
- clk  in  1  board clock, all logic on rising edge
- rst  in  1  reset; the only clock is clk, and rst is asynchronous and active-high
- en  in  1  scan enable; low holds the scan at its origin
- req_valid  out  1  pixel request pending
- req_x  out  10  column of the requested pixel
- req_y  out  10  row of the requested pixel
- req_ready  in  1  source accepts the request; req_rgb is valid in the same cycle
- req_rgb  in  12  {r,g,b}, 4 bits each
- r  out  4  red
- g  out  4  green
- b  out  4  blue
- HS  out  1  horizontal sync
- VS  out  1  vertical sync
- frame_start  out  1  one-clk pulse at frame origin
- underrun  out  1  sticky late-pixel flag
- underrun_clr  in  1  clears underrun

Behaviour:
- Timing totals: H_TOTAL = 800, V_TOTAL = 525.
- Reset values:
  - div, h, v = 0
  - r/g/b = 0
  - HS/VS inactive (1 when SYNC_NEG = 1)
  - req_valid = 0, frame_start = 0, underrun = 0
  - pixel latch empty
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_ce = (div == CLK_DIV-1) && en.
- Scan counters, on pix_ce:
  - h increments; at H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps from V_TOTAL-1 to 0.
  - frame_start pulses for one clk in the cycle after the (V_TOTAL-1, H_TOTAL-1) -> (0,0) wrap.
- Active area: h < H_ACTIVE && v < V_ACTIVE.
  - Sync regions: HS active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; VS uses the same rule on v.
- Request window:
  - Opens the clk after the scan reaches an active (h,v): req_valid = 1, req_x = h, req_y = v.
  - Held until req_valid && req_ready, or until the next pix_ce, whichever is first.
  - On handshake, req_rgb is latched and req_valid drops.
  - At most one request per pixel.
- Output stage, at each pix_ce:
  - Loads the r/g/b/HS/VS for the (h,v) currently held in the counters; output latency is exactly one pixel period, identical for colour and sync.
  - Active pixel, latch full -> latched colour.
  - Active pixel, handshake completing in the pix_ce cycle itself -> req_rgb bypassed directly.
  - Active pixel, neither -> UNDERRUN_RGB, and underrun set.
  - Blanking pixel -> 0.
  - The latch empties at every pix_ce.
- underrun:
  - Set on a miss; cleared by underrun_clr.
  - Set and clear in the same cycle -> set wins.
- en low:
  - Next clk: div, h, v = 0; req_valid = 0; latch empty.
  - r/g/b = 0; HS/VS inactive; no frame_start.
- en rising: first pix_ce occurs CLK_DIV clks later, and the scan starts at (0,0).
- rst mid-frame: immediate return to the reset values, independent of clk.

Decomposition:
- Package vga_pkg holds:
  - the default timing constants and derived H_TOTAL/V_TOTAL;
  - RGB_W = 12;
  - typedef rgb444_t (packed r/g/b nibbles);
  - a sync-polarity helper constant.
- Sub-module vga_pix_ce_gen (divider plus en gating) is natural; scan counters, request FSM (IDLE, REQ, HAVE) and output registers stay in the top.

Test Plan:
- Reset release, en = 1, source always ready:
  - HS period 800 pix_ce = 4000 clk, low for 96 pix_ce;
  - VS low for 2 lines;
  - frame_start every 2,100,000 clk;
  - underrun stays 0.
- Source returns req_rgb = {4'hA,4'h5,4'h3} for every request: r/g/b = A/5/3 for exactly 640 pixels per line and 480 lines; 0 in blanking.
- Delay req_ready for pixel (10,3) beyond its window -> that pixel outputs F/0/F, underrun = 1 and stays set; underrun_clr pulse -> 0.
- req_ready in the same cycle as pix_ce for (20,5) -> req_rgb bypassed to the output, underrun stays 0.
- Drop en at (300,200) for 7 clk, then raise it -> req_valid = 0 and outputs blank within 1 clk; the first request after re-enable is (0,0), CLK_DIV clk later.
- Assert rst asynchronously mid-line between clk edges -> all outputs take their reset values before the next clk edge.
